// File: rtl/rename_pkg.sv
// Shared rename-stage types: physical register index width and preg type.
package rename_pkg;

    localparam int NUM_PHYSREG = 128;
    localparam int NUM_AREG    = 32;
    localparam int PREG_W      = $clog2(NUM_PHYSREG);

    typedef logic [PREG_W-1:0] preg_t;

endpackage : rename_pkg

// File: rtl/preg_release_queue.sv
// Multi-push (PUSH_W lanes, compacted low-first), single-pop circular buffer
// of stale physical registers awaiting release.
module preg_release_queue
    import rename_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PUSH_W = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PUSH_W-1:0]          push_mask,
    input  preg_t [PUSH_W-1:0]         push_data,
    input  logic                       pop,
    output preg_t                      head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    preg_t             mem_q [DEPTH];
    preg_t             mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  n_push;
    logic [PTR_W-1:0]  slot;

    // Write pushed lanes into consecutive slots from the tail; advance pointers and count.
    always_comb begin
        mem_d  = mem_q;
        n_push = '0;
        slot   = '0;
        for (int i = 0; i < PUSH_W; i++) begin
            if (push_mask[i]) begin
                slot        = wr_ptr_q + n_push[PTR_W-1:0];
                mem_d[slot] = push_data[i];
                n_push      = n_push + CNT_W'(1);
            end
        end
        wr_ptr_d = wr_ptr_q + n_push[PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + n_push - CNT_W'(pop);
    end

    // Queue state registers; reset empties the queue and drops any pending entries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule : preg_release_queue

// File: rtl/preg_release_unit.sv
// Return side of the physical-register free list: buffers stale pregs from
// retiring instructions and writes them, one per cycle, at the free-list tail.
module preg_release_unit
    import rename_pkg::*;
#(
    parameter int PHYSREG  = NUM_PHYSREG,
    parameter int AREG     = NUM_AREG,
    parameter int RETIRE_W = 2,
    parameter int QDEPTH   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [RETIRE_W-1:0]          retire_valid_i,
    input  logic [RETIRE_W-1:0]          retire_has_old_i,
    input  logic [RETIRE_W*PREG_W-1:0]   retire_old_preg_i,
    output logic                         retire_ready_o,
    input  logic                         recover_i,
    input  logic [PREG_W:0]              free_count_i,
    input  logic [PREG_W-1:0]            free_tail_i,
    output logic                         free_en_o,
    output logic                         list_we_o,
    output logic [PREG_W-1:0]            list_waddr_o,
    output logic [PREG_W-1:0]            list_wdata_o,
    output logic [$clog2(QDEPTH):0]      pending_o,
    output logic                         err_o
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    // Ready only when a full retire group is guaranteed to fit.
    localparam logic [CNT_W-1:0]  READY_MAX = CNT_W'(QDEPTH - RETIRE_W);
    // Free count at which the list is full; releasing more would be a double free.
    localparam logic [PREG_W:0]   FREE_MAX  = (PREG_W + 1)'(PHYSREG - AREG);

    logic [RETIRE_W-1:0]          lane_take;
    logic [RETIRE_W-1:0]          push_mask;
    preg_t [RETIRE_W-1:0]         push_data;
    preg_t                        head_data;
    logic [CNT_W-1:0]             count;
    logic                         q_nonempty;
    logic                         drain;
    logic                         drop;
    logic                         pop;
    logic                         err_q, err_d;

    assign retire_ready_o = (count <= READY_MAX);
    assign lane_take      = retire_valid_i & retire_has_old_i & {RETIRE_W{retire_ready_o}};

    // Compact accepted lanes into the low push slots, preserving lane order.
    always_comb begin
        int k;
        k         = 0;
        push_mask = '0;
        push_data = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            if (lane_take[i]) begin
                for (int j = 0; j < RETIRE_W; j++) begin
                    if (j == k) begin
                        push_mask[j] = 1'b1;
                        push_data[j] = retire_old_preg_i[i*PREG_W +: PREG_W];
                    end
                end
                k = k + 1;
            end
        end
    end

    preg_release_queue #(
        .DEPTH  (QDEPTH),
        .PUSH_W (RETIRE_W)
    ) u_queue (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_mask (push_mask),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    // Drain decision: release the head normally, or drop it when the list is already full.
    // Recovery freezes the queue so no retired release is lost.
    always_comb begin
        q_nonempty   = (count != '0);
        drain        = q_nonempty & ~recover_i & (free_count_i <  FREE_MAX);
        drop         = q_nonempty & ~recover_i & (free_count_i >= FREE_MAX);
        pop          = drain | drop;
        err_d        = err_q | drop;
        free_en_o    = drain;
        list_we_o    = drain;
        list_waddr_o = drain ? free_tail_i : '0;
        list_wdata_o = drain ? head_data   : '0;
    end

    // Sticky double-free flag, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o     = err_q;
    assign pending_o = count;

    // Retiring while not ready is a protocol violation; such lanes are ignored.
    a_no_retire_when_full: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !retire_ready_o |-> (retire_valid_i == '0)
    );

endmodule : preg_release_unit
